multiple_gen_seq: RTL
=====================

Name: multiple_gen_seq

Overview:
Sequential, parametrised generator of the operand multiples 1·A … NUM_MULT·A that feed the partial-product selectors of the radix-N multiplier datapath. It uses a single shared adder and a register bank: one new multiple is produced per cycle. Results are full-width, with no truncation, and cover both signed and unsigned operands. The block sits between the operand FIFO and the partial-product mux array, with valid/ready handshakes on both sides.

Parameters:
SIZE, 18, operand width in bits.
NUM_MULT, 4, highest multiple generated; legal range 2..16.
OUT_W, SIZE+$clog2(NUM_MULT+1), width of each multiple; derived, not overridable.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  synchronous reset, active-low.
in_valid_i  in  1  operand valid.
in_ready_o  out  1  block can accept an operand.
a_i  in  SIZE  operand A.
signed_i  in  1  1 = A is two's complement, 0 = unsigned; sampled with A.
out_valid_o  out  1  multiples bank complete and stable.
out_ready_i  in  1  consumer accepts the bank.
multiples_o  out  NUM_MULT*OUT_W  flattened bank; slice k-1 holds k·A, k = 1..NUM_MULT.

Behaviour:
- Reset: one clock, synchronous and active-low (rst_ni sampled on the rising edge of clk_i). Reset puts the FSM in IDLE and clears all bank registers to 0. After reset: out_valid_o=0, multiples_o=0. in_ready_o=0 while rst_ni=0 and 1 once in IDLE.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On the edge where in_valid_i=1: latch A_ext, the sign- or zero-extension of a_i to OUT_W according to signed_i. Write bank[1]=A_ext, set idx=2, go to CALC.
- CALC:
  - in_ready_o=0.
  - Each cycle: bank[idx]=bank[idx-1]+A_ext in OUT_W arithmetic, then idx++.
  - On the edge that writes bank[NUM_MULT], go to DONE.
- DONE:
  - out_valid_o=1; multiples_o holds stable.
  - On the edge where out_ready_i=1, go to IDLE.
  - No same-cycle accept of a new operand: in_ready_o rises one cycle after the output handshake.
- Latency: operand accepted at edge t → out_valid_o=1 after edge t+NUM_MULT-1. Throughput is one operand per NUM_MULT+1 cycles minimum.
- Width: OUT_W is sufficient for NUM_MULT·A in both modes. Overflow cannot occur and no saturation logic exists.
- In signed mode multiples_o slices are two's complement; in unsigned mode the upper bits are zero.
- Bank contents persist after the output handshake until overwritten by the next operand; they are not cleared.
- Backpressure: out_ready_i=0 holds DONE and out_valid_o indefinitely with the bank unchanged.
- in_valid_i outside IDLE is ignored. a_i and signed_i changes after accept have no effect.
- Reset mid-CALC or in DONE: on the next reset edge go to IDLE, zero the bank, drop out_valid_o. No partial result is ever flagged valid.
- out_valid_o and multiples_o are driven from registers only, with no combinational path from inputs.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum mg_state_e {IDLE, CALC, DONE};
  - a function mg_out_w(size, num_mult) returning OUT_W, which the partial-product mux uses to size its inputs.
- No sub-module. The adder and bank are small enough to stay inline; an index counter of $clog2(NUM_MULT+1) bits drives the bank write enable.

Test Plan:
- Unsigned basic, SIZE=18, NUM_MULT=4: A=5, signed=0, out_ready held 1 → out_valid after 3 edges; slices 5,10,15,20; in_ready back to 1 two cycles after accept+3.
- Signed negative: A=18'h3FFFD (−3), signed=1 → OUT_W=21 slices 21'h1FFFFD, 21'h1FFFFA, 21'h1FFFF7, 21'h1FFFF4 (−3,−6,−9,−12).
- Max unsigned: A=18'h3FFFF, signed=0 → 4·A=21'h0FFFFC, 3·A=21'h0BFFFD; no wrap.
- Backpressure plus ignored input:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with A=7.
  - Required: out_valid stays 1, bank unchanged and equal to the prior operand's multiples, in_ready=0 throughout.
  - After out_ready=1: next accepted A=7 gives 7,14,21,28.
- Reset mid-CALC: accept A=9, assert rst_ni=0 for one edge during CALC → out_valid=0, multiples_o=0, in_ready=1 one cycle after release.
- NUM_MULT=8 build: A=3 → slices 3..24 in steps of 3; out_valid after 7 edges; OUT_W=22.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the operand-multiple generator and the partial-product
// mux array that consumes its bank.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mg_state_e;

  // Width of one multiple: wide enough to hold num_mult * A in either signedness.
  function automatic int mg_out_w(input int size, input int num_mult);
    return size + $clog2(num_mult + 1);
  endfunction

endpackage

// File: rtl/multiple_gen_seq.sv
// Sequential generator of 1*A .. NUM_MULT*A using one shared adder and a
// register bank; one new multiple per cycle, full width, signed or unsigned.
module multiple_gen_seq
  import mult_pkg::*;
#(
  parameter int SIZE     = 18,
  parameter int NUM_MULT = 4
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic                                             in_valid_i,
  output logic                                             in_ready_o,
  input  logic [SIZE-1:0]                                  a_i,
  input  logic                                             signed_i,
  output logic                                             out_valid_o,
  input  logic                                             out_ready_i,
  output logic [NUM_MULT*mult_pkg::mg_out_w(SIZE, NUM_MULT)-1:0] multiples_o
);

  localparam int OUT_W = mg_out_w(SIZE, NUM_MULT);
  localparam int IDX_W = $clog2(NUM_MULT + 1);

  mg_state_e               state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic                    last;
  logic signed [OUT_W-1:0] a_ext;
  logic signed [OUT_W-1:0] a_in_ext;
  logic signed [OUT_W-1:0] bank [1:NUM_MULT];
  logic signed [OUT_W-1:0] prev;
  logic signed [OUT_W-1:0] sum;

  function automatic logic signed [OUT_W-1:0] extend(input logic [SIZE-1:0] a,
                                                     input logic           s);
    logic signed [OUT_W-1:0] r;
    r = s ? {{(OUT_W-SIZE){a[SIZE-1]}}, a} : {{(OUT_W-SIZE){1'b0}}, a};
    return r;
  endfunction

  assign a_in_ext = extend(a_i, signed_i);
  assign last     = (idx == IDX_W'(NUM_MULT));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid_i)  state_nxt = CALC;
      CALC:    if (last)        state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  assign in_ready_o  = rst_ni && (state == IDLE);
  assign out_valid_o = (state == DONE);

  // Shared adder: previous multiple selected by the index counter, plus A.
  always_comb begin
    prev = '0;
    for (int k = 1; k < NUM_MULT; k++) begin
      if (idx == IDX_W'(k + 1)) prev = bank[k];
    end
    sum = prev + a_ext;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_ext <= '0;
      idx   <= '0;
      for (int k = 1; k <= NUM_MULT; k++) bank[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a_ext   <= a_in_ext;
            bank[1] <= a_in_ext;
            idx     <= IDX_W'(2);
          end
        end
        CALC: begin
          for (int k = 2; k <= NUM_MULT; k++) begin
            if (idx == IDX_W'(k)) bank[k] <= sum;
          end
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 1; k <= NUM_MULT; k++) begin : g_out
    assign multiples_o[(k-1)*OUT_W +: OUT_W] = bank[k];
  end

endmodule
